// File: rtl/draw_rect_char_if.sv
// VGA pixel-stream bundle: counters, sync/blank strobes and 12-bit colour.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_rect_char.sv
// Text overlay: a 16x16 grid of 8x16 glyphs at (X0,Y0), fed by external
// char-code and font ROMs with a fixed two-cycle round trip.
module draw_rect_char #(
  parameter logic [10:0] X0       = 11'd16,
  parameter logic [10:0] Y0       = 11'd16,
  parameter logic [11:0] FG_COLOR = 12'hFFF
) (
  input  logic       clk,
  input  logic       rst,
  vga_if.in          vii,
  vga_if.out         vio,
  output logic [7:0] char_xy,
  output logic [3:0] char_line,
  input  logic [7:0] char_pixels
);

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    vga_t       pix;
    logic       in_area;
    logic [2:0] x_pix;
  } stage_t;

  function automatic logic area_hit(input logic [10:0] h, input logic [10:0] v);
    logic [11:0] h_ext;
    logic [11:0] v_ext;
    h_ext = {1'b0, h};
    v_ext = {1'b0, v};
    return (h_ext >= {1'b0, X0}) && (h_ext < ({1'b0, X0} + 12'd128)) &&
           (v_ext >= {1'b0, Y0}) && (v_ext < ({1'b0, Y0} + 12'd256));
  endfunction

  function automatic logic glyph_bit(input logic [7:0] pixels, input logic [2:0] idx);
    return pixels[3'd7 - idx];
  endfunction

  logic       in_area;
  logic [6:0] x_rel;
  logic [7:0] y_rel;

  logic [7:0] char_xy_d,   char_xy_q;
  logic [3:0] char_line_d, char_line_q;
  stage_t     stg_p1_d, stg_p1_q;
  stage_t     stg_p2_d, stg_p2_q;
  stage_t     stg_p3_d, stg_p3_q;
  vga_t       out_d,    out_q;

  always_comb begin
    // Stage 0 -> 1: area test and ROM addressing on the live input.
    in_area = area_hit(vii.hcount, vii.vcount);
    // Only the low bits of the offsets are ever consumed; modular subtraction
    // on the narrowed operands yields the same bits.
    x_rel = vii.hcount[6:0] - X0[6:0];
    y_rel = vii.vcount[7:0] - Y0[7:0];

    char_xy_d   = in_area ? {y_rel[7:4], x_rel[6:3]} : 8'd0;
    char_line_d = in_area ? y_rel[3:0] : 4'd0;

    stg_p1_d.pix.hcount = vii.hcount;
    stg_p1_d.pix.vcount = vii.vcount;
    stg_p1_d.pix.hsync  = vii.hsync;
    stg_p1_d.pix.vsync  = vii.vsync;
    stg_p1_d.pix.hblnk  = vii.hblnk;
    stg_p1_d.pix.vblnk  = vii.vblnk;
    stg_p1_d.pix.rgb    = vii.rgb;
    stg_p1_d.in_area    = in_area;
    stg_p1_d.x_pix      = x_rel[2:0];

    // Stages 1 -> 3: pure delay covering the ROM round trip.
    stg_p2_d = stg_p1_q;
    stg_p3_d = stg_p2_q;

    // Stage 3 -> output: glyph bit from the font ROM selects the overlay.
    out_d = stg_p3_q.pix;
    if (stg_p3_q.in_area && glyph_bit(char_pixels, stg_p3_q.x_pix) &&
        !(stg_p3_q.pix.hblnk || stg_p3_q.pix.vblnk)) begin
      out_d.rgb = FG_COLOR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      char_xy_q   <= '0;
      char_line_q <= '0;
      stg_p1_q    <= '0;
      stg_p2_q    <= '0;
      stg_p3_q    <= '0;
      out_q       <= '0;
    end else begin
      char_xy_q   <= char_xy_d;
      char_line_q <= char_line_d;
      stg_p1_q    <= stg_p1_d;
      stg_p2_q    <= stg_p2_d;
      stg_p3_q    <= stg_p3_d;
      out_q       <= out_d;
    end
  end

  assign char_xy    = char_xy_q;
  assign char_line  = char_line_q;
  assign vio.hcount = out_q.hcount;
  assign vio.vcount = out_q.vcount;
  assign vio.hsync  = out_q.hsync;
  assign vio.vsync  = out_q.vsync;
  assign vio.hblnk  = out_q.hblnk;
  assign vio.vblnk  = out_q.vblnk;
  assign vio.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_rect_char.sv
// Bench for draw_rect_char: registered char/font ROM models plus a per-pixel
// reference computed from grid geometry, checked every cycle.
module tb_draw_rect_char;
  localparam int X0 = 16;
  localparam int Y0 = 16;
  localparam logic [11:0] FG = 12'hFFF;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] char_xy;
  logic [3:0] char_line;
  logic [7:0] char_pixels = 8'd0;

  vga_if vii();
  vga_if vio();

  draw_rect_char #(.X0(11'd16), .Y0(11'd16), .FG_COLOR(12'hFFF)) dut (
    .clk(clk), .rst(rst), .vii(vii), .vio(vio),
    .char_xy(char_xy), .char_line(char_line), .char_pixels(char_pixels)
  );

  always #5 clk = ~clk;

  // External ROMs: char code one cycle after the address, glyph row one after that.
  logic [7:0] char_rom [256];
  logic [7:0] font_rom [4096];
  logic [7:0] code_q = 8'd0;
  logic [3:0] line_q = 4'd0;
  int         font_mode = 0;

  always @(posedge clk) begin
    code_q <= char_rom[char_xy];
    line_q <= char_line;
    if (font_mode == 1)      char_pixels <= 8'hFF;
    else if (font_mode == 2) char_pixels <= 8'b1000_0001;
    else                     char_pixels <= font_rom[{code_q, line_q}];
  end

  typedef struct {
    logic        rst;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
    int          mode;
  } pix_t;

  typedef struct {
    logic [10:0] h;
    logic [10:0] v;
    logic [7:0]  xy;
    logic [3:0]  line;
  } addr_vec_t;

  pix_t hist[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic bit in_area(input pix_t p);
    int h, v;
    h = p.hcount;
    v = p.vcount;
    return (h >= X0) && (h < X0 + 128) && (v >= Y0) && (v < Y0 + 256);
  endfunction

  function automatic logic [37:0] model_vio(input pix_t p);
    int xr, yr, code, bits;
    logic [11:0] rgb;
    rgb = p.rgb;
    if (in_area(p)) begin
      xr = int'(p.hcount) - X0;
      yr = int'(p.vcount) - Y0;
      code = char_rom[(yr / 16) * 16 + xr / 8];
      if (p.mode == 1)      bits = 8'hFF;
      else if (p.mode == 2) bits = 8'h81;
      else                  bits = font_rom[code * 16 + yr % 16];
      if (((bits >> (7 - xr % 8)) & 1) == 1 && !(p.hblnk || p.vblnk)) rgb = FG;
    end
    return {p.hcount, p.vcount, p.hsync, p.vsync, p.hblnk, p.vblnk, rgb};
  endfunction

  function automatic logic [11:0] model_addr(input pix_t p);
    int xr, yr;
    if (p.rst || !in_area(p)) return 12'd0;
    xr = int'(p.hcount) - X0;
    yr = int'(p.vcount) - Y0;
    return {4'(yr / 16), 4'(xr / 8), 4'(yr % 16)};
  endfunction

  task automatic cycle(input pix_t p);
    int  j;
    bit  zero;
    logic [37:0] exp_vio;
    p.mode = font_mode;
    rst        = p.rst;
    vii.hcount = p.hcount;
    vii.vcount = p.vcount;
    vii.hsync  = p.hsync;
    vii.vsync  = p.vsync;
    vii.hblnk  = p.hblnk;
    vii.vblnk  = p.vblnk;
    vii.rgb    = p.rgb;
    hist.push_back(p);
    @(posedge clk);
    #1;
    j = hist.size() - 1;
    zero = 1'b0;
    for (int k = j - 3; k <= j; k++)
      if (k < 0 || hist[k].rst) zero = 1'b1;
    exp_vio = zero ? 38'd0 : model_vio(hist[j - 3]);
    check("vio", {vio.hcount, vio.vcount, vio.hsync, vio.vsync, vio.hblnk, vio.vblnk, vio.rgb},
          exp_vio);
    check("addr", {char_xy, char_line}, model_addr(p));
  endtask

  function automatic pix_t mk(input logic [10:0] h, input logic [10:0] v,
                              input logic [11:0] rgb, input logic hb);
    pix_t p;
    p.rst = 1'b0; p.hcount = h; p.vcount = v;
    p.hsync = 1'b0; p.vsync = 1'b0; p.hblnk = hb; p.vblnk = 1'b0;
    p.rgb = rgb; p.mode = 0;
    return p;
  endfunction

  task automatic set_mode(input int m);
    for (int i = 0; i < 3; i++) cycle(mk(11'd0, 11'd0, 12'h000, 1'b0));
    font_mode = m;
  endtask

  initial begin
    addr_vec_t avec [6];
    pix_t p;

    for (int i = 0; i < 256; i++)  char_rom[i] = 8'($urandom);
    for (int i = 0; i < 4096; i++) font_rom[i] = 8'($urandom);

    avec[0] = '{11'd59,  11'd55,  8'h25, 4'h7};
    avec[1] = '{11'd15,  11'd55,  8'h00, 4'h0};
    avec[2] = '{11'd143, 11'd271, 8'hFF, 4'hF};
    avec[3] = '{11'd144, 11'd100, 8'h00, 4'h0};
    avec[4] = '{11'd16,  11'd16,  8'h00, 4'h0};
    avec[5] = '{11'd100, 11'd272, 8'h00, 4'h0};

    // Reset held three cycles with live data on the input.
    p = mk(11'd50, 11'd20, 12'hABC, 1'b0);
    p.rst = 1'b1;
    for (int i = 0; i < 3; i++) cycle(p);
    p.rst = 1'b0;
    for (int i = 0; i < 5; i++) cycle(p);

    // Addressing table.
    set_mode(1);
    foreach (avec[i]) begin
      cycle(mk(avec[i].h, avec[i].v, 12'h321, 1'b0));
      check("addr_table", {char_xy, char_line}, {avec[i].xy, avec[i].line});
    end

    // Pass-through latency, outside the area with an all-ones glyph.
    cycle(mk(11'd400, 11'd300, 12'h123, 1'b0));
    for (int i = 0; i < 3; i++) cycle(mk(11'd401 + 11'(i), 11'd300, 12'h000, 1'b0));
    check("latency", {vio.hcount, vio.vcount, vio.rgb}, {11'd400, 11'd300, 12'h123});

    // Glyph bit select across one cell.
    set_mode(2);
    for (int x = 0; x < 8; x++) cycle(mk(11'(X0 + x), 11'(Y0 + 3), 12'h0A5, 1'b0));
    set_mode(1);

    // Area edges on the last inside line and the first outside line.
    for (int v = Y0 + 255; v <= Y0 + 256; v++)
      for (int h = X0 - 1; h <= X0 + 128; h++)
        cycle(mk(11'(h), 11'(v), 12'h456, 1'b0));

    // Blanking suppresses the overlay.
    cycle(mk(11'd40, 11'd40, 12'h789, 1'b1));
    for (int i = 0; i < 3; i++) cycle(mk(11'd0, 11'd0, 12'h000, 1'b0));
    check("blank", {vio.hblnk, vio.rgb}, {1'b1, 12'h789});

    // Random traffic against the real font table, with occasional mid-frame reset.
    set_mode(0);
    for (int i = 0; i < 2000; i++) begin
      p.rst    = ($urandom_range(0, 199) == 0);
      p.hcount = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(X0 - 4, X0 + 132))
                                             : 11'($urandom_range(0, 1055));
      p.vcount = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(Y0 - 4, Y0 + 260))
                                             : 11'($urandom_range(0, 627));
      p.hsync  = 1'($urandom);
      p.vsync  = 1'($urandom);
      p.hblnk  = ($urandom_range(0, 4) == 0);
      p.vblnk  = ($urandom_range(0, 4) == 0);
      p.rgb    = 12'($urandom);
      cycle(p);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/draw_rect_char.md
# draw_rect_char

Text-overlay stage in the 40 MHz VGA pixel pipeline. It sits directly downstream of draw_rct and upstream of draw_mouse, taking the place of the pure delay stage between them, so the cursor is still drawn on top of the text. It renders a fixed 16×16 grid of 8×16-pixel characters at a parameterised screen position. For each pixel it:

- drives a character-grid address to an external character-code ROM;
- drives a glyph line index to an external font ROM;
- overlays the returned glyph bits on the incoming pixel stream;
- delays all timing signals to match the two-cycle external ROM latency.

## Interface
Parameters:
- X0, 16: left edge of text area (hcount units); text area is 128 px wide.
- Y0, 16: top edge of text area (vcount units); text area is 256 px tall.
- FG_COLOR, 12'hFFF: colour for set glyph bits.

Ports:
- clk  input  1  pixel clock (40 MHz); single clock domain.
- rst  input  1  reset; synchronous and active-high.
- vii  input  vga_if  upstream pixel stream:
  - hcount[10:0], vcount[10:0];
  - hsync, vsync, hblnk, vblnk;
  - rgb[11:0].
- vio  output  vga_if  downstream pixel stream; same fields, all registered.
- char_xy  output  8  {row[3:0], col[3:0]} to the char-code ROM; registered.
- char_line  output  4  glyph line (0 = top) to the font ROM; registered.
- char_pixels  input  8  glyph row from the font ROM; bit 7 = leftmost pixel.

## Operation
- External path is fixed and registered, two stages:
  - char ROM samples char_xy and produces a code one cycle later.
  - font ROM samples {code, char_line} and produces char_pixels one cycle after that.
- Area test on vii (combinational, cycle n):
  - in_area = (hcount >= X0) && (hcount < X0+128) && (vcount >= Y0) && (vcount < Y0+256).
- Relative coordinates:
  - x_rel = hcount - X0; y_rel = vcount - Y0; both 11-bit unsigned.
  - Comparisons are done before subtraction, so no wrap is ever used.
- Address outputs, registered at the end of cycle n:
  - If in_area: char_xy = {y_rel[7:4], x_rel[6:3]} and char_line = y_rel[3:0].
  - Otherwise both outputs are 0.
- Delay pipeline: 3 register stages carry the following, each stage updated every cycle:
  - hcount, vcount, hsync, vsync, hblnk, vblnk;
  - rgb;
  - in_area;
  - x_rel[2:0].
- Pixel select, in cycle n+3 using stage-3 values:
  - bit = char_pixels[7 - x_rel_d3].
  - A pixel is overlaid if in_area_d3 && bit && !(hblnk_d3 || vblnk_d3).
- Output register, end of cycle n+3:
  - vio timing fields = stage-3 values.
  - vio.rgb = FG_COLOR if overlaid, else rgb_d3.
- The block applies no background colour: non-glyph pixels inside the area pass through unchanged.
- The block holds no state beyond the pipeline. There is no FSM and no frame counter, so a frame-rate or position change upstream needs no resynchronisation.

## Timing
- Latency: a pixel present on vii in cycle n appears on vio in cycle n+4. All vio fields are aligned; hsync/vsync edges shift by exactly 4 cycles relative to vii.
- char_xy and char_line are valid in cycle n+1 for the pixel of cycle n.
- char_pixels is sampled in cycle n+3. The block expects exactly a 2-cycle round trip with no stall or valid handshake; ROM latency is fixed by design.
- Throughput: one pixel per clock, continuously, including blanking.
- Reset, while rst is high at an edge, clears all of the following to 0:
  - vio: hcount, vcount, hsync, vsync, hblnk, vblnk, rgb;
  - char_xy, char_line;
  - every delay stage.
- After rst deasserts, vio carries zeros for 3 further cycles. The first valid pixel appears 4 cycles after the first non-reset edge.
- Reset mid-frame behaves the same; no partial-character artefacts persist past the flushed pipeline.
- Boundary values:
  - hcount = X0-1 and hcount = X0+128 are outside the area.
  - vcount = Y0+255 is inside; vcount = Y0+256 is outside.
- The area may overlap blanking; blanking suppresses the overlay.

## Test plan
- Reset: hold rst 3 cycles while vii carries hcount=50, rgb=12'hABC → every vio field and char_xy/char_line read 0 from the first rst edge until 4 cycles after release.
- Pass-through latency: X0=16, Y0=16; drive hcount=400, vcount=300, rgb=12'h123 with char_pixels=8'hFF → vio shows 400/300/12'h123 exactly 4 cycles later, with no overlay.
- Addressing: hcount=59, vcount=55 (col 5, pixel 3, row 2, line 7) → char_xy=8'h25, char_line=4'h7 in the next cycle. hcount=15 → char_xy=0, char_line=0.
- Glyph bit select: ROM model returns 8'b1000_0001 for the cell at x_rel 0..7 → vio.rgb = FG_COLOR at x_rel 0 and 7; the incoming rgb at x_rel 1..6.
- Area edges: char_pixels forced 8'hFF; sweep hcount X0-1..X0+128 and vcount Y0+255..Y0+256 → FG only for hcount in X0..X0+127 on line Y0+255; none on line Y0+256.
- Blanking: in-area pixel with hblnk=1 and char_pixels=8'hFF → vio.rgb equals the delayed input rgb, and vio.hblnk=1 at n+4.
